// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer at the MEM/commit point of the core.
// Executes Zicsr read-modify-writes and takes ECALL, MRET and interrupts. It drives
// trap_taken / mret_exec pulses and the redirect PC back to the pipeline controller.
//
// Ports:
//   clk, reset          core clock, synchronous active-high reset
//   instr_valid_mem     MEM stage holds a real instruction
//   pc_mem              PC of the MEM-stage instruction
//   is_csr_mem          CSRRW/S/C(I) in MEM
//   is_ecall_mem        ECALL in MEM
//   is_mret_mem         MRET in MEM
//   csr_write_mem       write intent of the CSR instruction
//   fun3_mem            CSR op (write / set / clear, register or immediate form)
//   csr_addr_mem        CSR address
//   csr_wdata_mem       rs1 value or zero-extended zimm
//   ext_irq             external interrupt level (asynchronous)
//   timer_irq           timer interrupt level (synchronous)
//   stall_pipl          pipeline frozen, no state update
//   csr_rdata           pre-write value of the addressed CSR (combinational)
//   trap_taken          one-cycle trap entry pulse
//   mret_exec           one-cycle MRET commit pulse
//   redirect_pc         target PC while a pulse is high, otherwise 0
module csr_trap_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int unsigned HART_ID     = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid_mem,
    input  logic [31:0] pc_mem,
    input  logic        is_csr_mem,
    input  logic        is_ecall_mem,
    input  logic        is_mret_mem,
    input  logic        csr_write_mem,
    input  logic [2:0]  fun3_mem,
    input  logic [11:0] csr_addr_mem,
    input  logic [31:0] csr_wdata_mem,
    input  logic        ext_irq,
    input  logic        timer_irq,
    input  logic        stall_pipl,
    output logic [31:0] csr_rdata,
    output logic        trap_taken,
    output logic        mret_exec,
    output logic [31:0] redirect_pc
);

    localparam logic [11:0] AddrMstatus  = 12'h300;
    localparam logic [11:0] AddrMie      = 12'h304;
    localparam logic [11:0] AddrMtvec    = 12'h305;
    localparam logic [11:0] AddrMscratch = 12'h340;
    localparam logic [11:0] AddrMepc     = 12'h341;
    localparam logic [11:0] AddrMcause   = 12'h342;
    localparam logic [11:0] AddrMip      = 12'h344;
    localparam logic [11:0] AddrMcycle   = 12'hB00;
    localparam logic [11:0] AddrMcycleh  = 12'hB80;
    localparam logic [11:0] AddrMhartid  = 12'hF14;

    localparam logic [31:0] AlignMask = 32'hFFFF_FFFC;

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    state_e      state_q, state_d;
    logic [1:0]  flush_cnt_q, flush_cnt_d;
    logic        ext_sync1_q, ext_sync2_q;
    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic        mtie_q, mtie_d, meie_q, meie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mcause_q, mcause_d;
    logic [63:0] mcycle_q, mcycle_d;

    logic [31:0] mstatus_rd, mie_rd, mip_rd;
    logic [31:0] csr_old, csr_new;
    logic        op_ok, commit, irq_ext, irq_tmr, take_trap, take_mret, csr_we;

    assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
    assign mie_rd     = {20'b0, meie_q, 3'b0, mtie_q, 7'b0};
    assign mip_rd     = {20'b0, ext_sync2_q, 3'b0, timer_irq, 7'b0};

    always_comb begin
        csr_old = '0;
        unique case (csr_addr_mem)
            AddrMstatus:  csr_old = mstatus_rd;
            AddrMie:      csr_old = mie_rd;
            AddrMtvec:    csr_old = mtvec_q;
            AddrMscratch: csr_old = mscratch_q;
            AddrMepc:     csr_old = mepc_q;
            AddrMcause:   csr_old = mcause_q;
            AddrMip:      csr_old = mip_rd;
            AddrMcycle:   csr_old = mcycle_q[31:0];
            AddrMcycleh:  csr_old = mcycle_q[63:32];
            AddrMhartid:  csr_old = 32'(HART_ID);
            default:      csr_old = '0;
        endcase
    end

    assign csr_rdata = csr_old;

    // fun3[2] only selects the immediate form; the operand is already muxed upstream.
    always_comb begin
        op_ok   = 1'b1;
        csr_new = csr_old;
        case (fun3_mem)
            3'b001, 3'b101: csr_new = csr_wdata_mem;
            3'b010, 3'b110: csr_new = csr_old | csr_wdata_mem;
            3'b011, 3'b111: csr_new = csr_old & ~csr_wdata_mem;
            default:        op_ok   = 1'b0;
        endcase
    end

    assign commit    = instr_valid_mem & ~stall_pipl & (state_q == StRun);
    assign irq_ext   = ext_sync2_q & meie_q & mstatus_mie_q;
    assign irq_tmr   = timer_irq & mtie_q & mstatus_mie_q;
    assign take_trap = commit & (irq_ext | irq_tmr | is_ecall_mem);
    assign take_mret = commit & ~take_trap & is_mret_mem;
    assign csr_we    = commit & ~take_trap & ~take_mret & is_csr_mem & csr_write_mem & op_ok;

    // Sequencer and pulse outputs.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        trap_taken  = take_trap;
        mret_exec   = take_mret;
        redirect_pc = '0;
        if (take_trap) begin
            redirect_pc = mtvec_q;
        end else if (take_mret) begin
            redirect_pc = mepc_q;
        end
        unique case (state_q)
            StRun: begin
                if (take_trap || take_mret) begin
                    state_d     = StFlush;
                    flush_cnt_d = 2'd2;
                end
            end
            StFlush: begin
                if (!stall_pipl) begin
                    if (flush_cnt_q == 2'd0) begin
                        state_d = StRun;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 2'd1;
                    end
                end
            end
            default: state_d = StRun;
        endcase
    end

    // CSR next state; the counter runs regardless of stalls unless software loads it.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mtie_d         = mtie_q;
        meie_d         = meie_q;
        mtvec_d        = mtvec_q;
        mepc_d         = mepc_q;
        mscratch_d     = mscratch_q;
        mcause_d       = mcause_q;
        mcycle_d       = mcycle_q + 64'd1;
        if (take_trap) begin
            mepc_d         = pc_mem & AlignMask;
            mcause_d       = irq_ext ? 32'h8000_000B :
                             irq_tmr ? 32'h8000_0007 : 32'h0000_000B;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (take_mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (csr_we) begin
            case (csr_addr_mem)
                AddrMstatus: begin
                    mstatus_mie_d  = csr_new[3];
                    mstatus_mpie_d = csr_new[7];
                end
                AddrMie: begin
                    mtie_d = csr_new[7];
                    meie_d = csr_new[11];
                end
                AddrMtvec:    mtvec_d    = csr_new & AlignMask;
                AddrMscratch: mscratch_d = csr_new;
                AddrMepc:     mepc_d     = csr_new & AlignMask;
                AddrMcause:   mcause_d   = csr_new;
                AddrMcycle:   mcycle_d   = {mcycle_q[63:32], csr_new};
                AddrMcycleh:  mcycle_d   = {csr_new, mcycle_q[31:0]};
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StRun;
            flush_cnt_q    <= 2'd0;
            ext_sync1_q    <= 1'b0;
            ext_sync2_q    <= 1'b0;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mtie_q         <= 1'b0;
            meie_q         <= 1'b0;
            mtvec_q        <= MTVEC_RESET & AlignMask;
            mepc_q         <= '0;
            mscratch_q     <= '0;
            mcause_q       <= '0;
            mcycle_q       <= '0;
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            ext_sync1_q    <= ext_irq;
            ext_sync2_q    <= ext_sync1_q;
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mtie_q         <= mtie_d;
            meie_q         <= meie_d;
            mtvec_q        <= mtvec_d;
            mepc_q         <= mepc_d;
            mscratch_q     <= mscratch_d;
            mcause_q       <= mcause_d;
            mcycle_q       <= mcycle_d;
        end
    end

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
- Machine-mode CSR file and trap sequencer at the MEM/commit point of the 5-stage core.
- Consumes the CSR/ECALL/MRET decode flags after they have been carried through the ID/EXE/MEM registers.
- Executes Zicsr read-modify-writes and detects traps and interrupts.
- Returns trap_taken / mret_exec pulses to the pipeline controller, together with the redirect PC.

Parameters:
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.
- HART_ID, 0, value returned by mhartid.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- instr_valid_mem  in  1  MEM stage holds a real (non-bubble) instruction
- pc_mem  in  32  PC of the MEM-stage instruction
- is_csr_mem  in  1  MEM instruction is CSRRW/S/C(I)
- is_ecall_mem  in  1  MEM instruction is ECALL
- is_mret_mem  in  1  MEM instruction is MRET
- csr_write_mem  in  1  write intent (0 for CSRRS/C with rs1=x0/zimm=0)
- fun3_mem  in  3  CSR op: 001/101 write, 010/110 set, 011/111 clear
- csr_addr_mem  in  12  CSR address
- csr_wdata_mem  in  32  rs1 value or zero-extended zimm, already selected
- ext_irq  in  1  external interrupt, asynchronous level
- timer_irq  in  1  timer interrupt, synchronous level
- stall_pipl  in  1  pipeline frozen; no state update
- csr_rdata  out  32  old CSR value, forwarded to WB as rd data
- trap_taken  out  1  one-cycle pulse: trap entry
- mret_exec  out  1  one-cycle pulse: MRET committed
- redirect_pc  out  32  target PC, valid when trap_taken or mret_exec is high

Behaviour:
- Supported CSRs and their reset values:
  - mstatus 0x300: MIE bit3, MPIE bit7, MPP[12:11] read-only 2'b11; resets to 0x00001800.
  - mie 0x304: MTIE bit7, MEIE bit11; other bits read 0; resets to 0.
  - mtvec 0x305: bits[1:0] forced 0 (direct mode only); resets to MTVEC_RESET.
  - mscratch 0x340: resets to 0.
  - mepc 0x341: bits[1:0] forced 0; resets to 0.
  - mcause 0x342: resets to 0.
  - mip 0x344: read-only, MTIP=bit7 and MEIP=bit11 taken from the irq levels.
  - mcycle 0xB00 / mcycleh 0xB80: 64-bit cycle counter; writes load the addressed half.
  - mhartid 0xF14: read-only, returns HART_ID.
- Unimplemented addresses read 0; writes to them are ignored (no illegal-instruction trap).
- ext_irq passes through a 2-flop synchronizer. The synchronized value is the one seen by mip and by the trap logic.
- csr_rdata is a combinational read of the pre-write value at csr_addr_mem. mcycle reads return the current count.
- Commit condition: instr_valid_mem & ~stall_pipl & state==RUN. Nothing commits otherwise.
- CSR write on commit, when is_csr_mem & csr_write_mem:
  - write ops: new = wdata
  - set ops: new = old | wdata
  - clear ops: new = old & ~wdata
- mcycle increments every cycle, including during a stall. A software write to mcycle wins over the increment in that cycle.
- Interrupt pending:
  - irq_ext = MEIP & MEIE & mstatus.MIE
  - irq_tmr = MTIP & MTIE & mstatus.MIE
- Priority at commit is ext irq > timer irq > ECALL > MRET > CSR op. The winner suppresses all lower-priority actions, including the CSR write of the same instruction.
- Trap entry, for an irq or ECALL:
  - mepc <= pc_mem
  - mcause <= 0x8000000B (ext), 0x80000007 (timer), or 0x0000000B (ECALL)
  - MPIE <= MIE, then MIE <= 0
  - trap_taken=1 and redirect_pc = mtvec, both in the same cycle (registered outputs are not used).
- MRET: MIE <= MPIE, MPIE <= 1, mret_exec=1, redirect_pc = mepc.
- FSM:
  - RUN -> FLUSH on trap_taken or mret_exec.
  - FLUSH holds for 3 cycles (counter 2..0) while the pipeline controller clears IF/ID/EXE. It then returns to RUN.
  - In FLUSH, no commit, trap or irq is evaluated.
- stall_pipl high: no CSR or FSM update and no pulses. The FLUSH counter also holds.
- trap_taken and mret_exec are never high in the same cycle.
- When neither pulse is high, redirect_pc = 0.
- Reset mid-FLUSH returns the FSM to RUN and all CSRs to their reset values. The synchronizer flops are cleared.

Test Plan:
- CSRRW then CSRRS: CSRRW x?,mscratch with wdata=0xDEADBEEF, then CSRRS with wdata=0x0000FFFF -> the second read returns 0xDEADBEEF and mscratch becomes 0xDEADFFFF.
- ECALL: mtvec=0x100, MIE=1, ECALL at pc_mem=0x40 -> same cycle trap_taken=1, redirect_pc=0x100; then mepc=0x40, mcause=0xB, MIE=0, MPIE=1; FSM in FLUSH for 3 cycles.
- MRET: then MRET -> mret_exec=1, redirect_pc=0x40; MIE=1, MPIE=1.
- Simultaneous external irq and ECALL: MIE=1, MEIE=1, ext_irq asserted 2 cycles before an ECALL commit -> mcause=0x8000000B, a single trap_taken pulse, and the ECALL is not recorded.
- Timer irq gating: timer_irq=1 with MTIE=1, MIE=0 -> no trap. CSRRSI mstatus,8 -> trap taken in the first RUN commit after the write with mcause=0x80000007, and the CSRRSI's own write still completes.
- Stall and reset: stall_pipl=1 during an ECALL commit -> no trap until stall_pipl drops. Assert reset during FLUSH -> next cycle state RUN, mstatus=0x1800, mtvec=MTVEC_RESET, mcycle=0.
